i2c_request_arbiter: RTL and testbench
======================================

# i2c_request_arbiter

Bus-side controller that shares one `i2c_core` instance among `N_REQ` requesters. It grants one request at a time, round-robin, and drives the core's byte-wide register bus. For each granted request it:
- programs the slave address and transfer size,
- loads write data into the core memory,
- pulses START and polls status until done,
- reads back received bytes, then reports completion, NACK or timeout to the requester.

It sits in BUS_CLK domain between firmware engines (e.g. sensor pollers) and the core's `BUS_*` port.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..8)
- `ABUSWIDTH`, 16, core address width
- `TIMEOUT`, 65535, max poll cycles before abort (≥16)

Ports:
- `BUS_CLK`  in  1  clock
- `RST`  in  1  reset, synchronous, active-high; clock BUS_CLK
- `REQ`  in  N_REQ  request, level, one per requester
- `REQ_ADDR`  in  8*N_REQ  per requester `{slave[6:0], rw}`; rw=1 is read
- `REQ_LEN`  in  3*N_REQ  byte count, valid 1..4
- `REQ_WDATA`  in  32*N_REQ  write bytes; byte i in `[8i+7:8i]`
- `GNT`  out  N_REQ  one-hot, 1-cycle pulse when request latched
- `DONE`  out  N_REQ  one-hot, 1-cycle completion pulse
- `RDATA`  out  32  read bytes, same packing; valid with DONE
- `NACK`  out  1  slave NACK; valid with DONE
- `TMO`  out  1  timeout; valid with DONE
- `BUSY`  out  1  high from GNT through DONE
- `CORE_ADD`  out  ABUSWIDTH  core address
- `CORE_WR`  out  1  core write strobe
- `CORE_RD`  out  1  core read strobe
- `CORE_WDATA`  out  8  core write data
- `CORE_RDATA`  in  8  core read data; valid the cycle after `CORE_RD`

## Operation
- Core map constants: reg 0 = soft reset; reg 1 = START on write, status on read (bit0 DONE, bit1 NO_ACK); reg 2 = I2C address; reg 3/4 = size lo/hi; memory at 8+i.
- FSM states: `IDLE, GRANT, W_ADDR, W_SIZEL, W_SIZEH, W_MEM, W_START, POLL_RD, POLL_CHK, M_RD, M_CAP, ABORT, RESP`.
- **IDLE:** if any `REQ` is set, the round-robin winner is the lowest index above the last-granted index, wrapping. Go to GRANT.
- **GRANT:** pulse `GNT`; latch addr/len/wdata.
  - If len is 0 or greater than 4: set TMO=0, NACK=1, go to RESP. No core access.
- **W_ADDR:** write reg2=addr. **W_SIZEL:** write reg3=len. **W_SIZEH:** write reg4=0.
- **W_MEM:** only if rw=0. Writes bytes 0..len-1 to 8..8+len-1, one per cycle.
- **W_START:** write reg1=0x00. Clear the poll counter.
- **POLL_RD:** read reg1. **POLL_CHK:** sample `CORE_RDATA`.
  - bit0=1: latch NACK=bit1. If rw=1 and NACK=0, go to M_RD; else go to RESP.
  - bit0=0: increment counter and return to POLL_RD.
  - Counter reaches TIMEOUT: go to ABORT.
- **M_RD:** read 8+i. **M_CAP:** capture `CORE_RDATA` into byte i. Repeat for i = 0..len-1, 2 cycles per byte. Bytes ≥ len read as 0.
- **ABORT:** write reg0 (soft reset of core). Set TMO=1, NACK=0. Go to RESP.
- **RESP:** pulse `DONE[id]`; RDATA/NACK/TMO are held until the next GNT. Return to IDLE.
- Requester protocol: `REQ` must be low in the cycle after DONE, else the requester is re-arbitrated. Requests arriving while BUSY wait. `REQ` dropped before GNT is a withdrawal.
- Never more than one of `CORE_WR`/`CORE_RD` per cycle; addresses never exceed 12. `CORE_WDATA` = 0 when not writing.

## Timing
- Reset values: all outputs 0, state IDLE, last-granted pointer = N_REQ-1 (so requester 0 wins first).
- RST mid-transaction: immediate IDLE with no DONE pulse; strobes drop the same cycle. The core is reset by the shared system reset.
- IDLE→GNT: 1 cycle after `REQ` is seen.
- Write of n bytes, from GNT to first POLL_RD: 5+n cycles. Read: 5 cycles.
- Each poll iteration takes 2 cycles.
- Read capture adds 2·len cycles after DONE is detected.
- DONE follows the final capture or status check by 1 cycle.
- Simultaneous REQ from all requesters: serviced in strict rotation.

## Structure
- Package `i2c_arb_pkg`: FSM state enum; core register constants (REG_RST, REG_START, REG_ADDR, REG_SIZE_L, REG_SIZE_H, MEM_BASE=8); status bit indices.
- Sub-module `rr_arbiter` (N_REQ, combinational winner plus registered last-grant pointer, update on grant).

## Test plan
- Write: req0 addr 0xA0, len 2, wdata 0x..BEEF → core writes reg2=A0, reg3=2, reg4=0, 8←EF, 9←BE, reg1; status 0x01 → DONE[0], NACK=0, TMO=0.
- Read: req1 addr 0xA1, len 3; core model memory 11/22/33 → RDATA=0x00332211, 3 M_RD/M_CAP pairs, no memory writes.
- NACK: status returns 0x03 on third poll → DONE with NACK=1; no memory read-back for rw=1.
- Timeout: TIMEOUT=20, status stays 0x00 → 20 polls, write to reg0, DONE with TMO=1.
- Arbitration: REQ=2'b11 held continuously (dropped only on the cycle after DONE each time) → grants 0,1,0; len=0 request → DONE with NACK=1 and zero core strobes.
- RST asserted during W_MEM → next cycle all outputs 0, IDLE; a new request then completes normally.

Source files
------------

// File: rtl/i2c_request_arbiter_pkg.sv
// i2c_arb_pkg: shared definitions for i2c_request_arbiter.
//   - arbiter FSM state encoding
//   - i2c_core register map (byte-wide BUS_* register bus)
//   - status register bit positions and transfer size limit
package i2c_arb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GRANT,
    W_ADDR,
    W_SIZEL,
    W_SIZEH,
    W_MEM,
    W_START,
    POLL_RD,
    POLL_CHK,
    M_RD,
    M_CAP,
    ABORT,
    RESP
  } state_t;

  // i2c_core register map
  localparam logic [3:0] REG_RST    = 4'd0;  // write: soft reset
  localparam logic [3:0] REG_START  = 4'd1;  // write: START, read: status
  localparam logic [3:0] REG_ADDR   = 4'd2;
  localparam logic [3:0] REG_SIZE_L = 4'd3;
  localparam logic [3:0] REG_SIZE_H = 4'd4;
  localparam logic [3:0] MEM_BASE   = 4'd8;

  // status register bits
  localparam int unsigned ST_DONE = 0;
  localparam int unsigned ST_NACK = 1;

  localparam int unsigned MAX_LEN = 4;

  // Core memory address of data byte i (0..3).
  function automatic logic [3:0] mem_addr(input logic [1:0] i);
    return MEM_BASE | {2'b00, i};
  endfunction

endpackage

// File: rtl/i2c_request_arbiter_if.sv
// i2c_request_arbiter_if: byte-wide register bus between the arbiter and
// the shared i2c_core.
//   CORE_ADD   register/memory address
//   CORE_WR    write strobe (CORE_WDATA valid)
//   CORE_RD    read strobe (CORE_RDATA valid the following cycle)
//   CORE_WDATA write data, zero when not writing
//   CORE_RDATA read data from the core
// master: arbiter side, slave: core side.
interface i2c_request_arbiter_if #(
  parameter int unsigned ABUSWIDTH = 16
);
  logic [ABUSWIDTH-1:0] CORE_ADD;
  logic                 CORE_WR;
  logic                 CORE_RD;
  logic [7:0]           CORE_WDATA;
  logic [7:0]           CORE_RDATA;

  modport master (
    output CORE_ADD, CORE_WR, CORE_RD, CORE_WDATA,
    input  CORE_RDATA
  );

  modport slave (
    input  CORE_ADD, CORE_WR, CORE_RD, CORE_WDATA,
    output CORE_RDATA
  );
endinterface

// File: rtl/i2c_request_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin requester selection.
//   BUS_CLK, RST  clock, synchronous active-high reset
//   req           request vector
//   grant_en      commit win_id as the new last-granted pointer
//   win_id        lowest requesting index above the last grant, wrapping
//   win_vld       at least one request present
// After reset the pointer sits at N_REQ-1 so requester 0 wins first.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 2,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic             BUS_CLK,
  input  logic             RST,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_en,
  output logic [IW-1:0]    win_id,
  output logic             win_vld
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned c;
    win_id  = '0;
    win_vld = 1'b0;
    c       = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      c = 32'(ptr_q) + off;
      if (c >= N_REQ) c = c - N_REQ;
      if (!win_vld && req[IW'(c)]) begin
        win_vld = 1'b1;
        win_id  = IW'(c);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) ptr_d = win_id;
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) ptr_q <= IW'(N_REQ - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/i2c_request_arbiter.sv
// i2c_request_arbiter: shares one i2c_core among N_REQ requesters.
// Grants requests round-robin, programs address/size, loads write bytes,
// starts the core, polls status (bounded by TIMEOUT polls), reads back
// received bytes and reports DONE with NACK/TMO.
//   BUS_CLK, RST  clock, synchronous active-high reset
//   REQ           level request per requester
//   REQ_ADDR      {slave[6:0], rw} per requester (rw=1 read)
//   REQ_LEN       byte count 1..4 per requester
//   REQ_WDATA     write bytes per requester, byte i at [8i+7:8i]
//   GNT, DONE     one-hot single-cycle pulses
//   RDATA         read bytes, NACK, TMO: valid with DONE, held to next GNT
//   BUSY          high from GNT through DONE
//   bus           core register bus (master side)
module i2c_request_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ABUSWIDTH = 16,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                  BUS_CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [8*N_REQ-1:0]    REQ_ADDR,
  input  logic [3*N_REQ-1:0]    REQ_LEN,
  input  logic [32*N_REQ-1:0]   REQ_WDATA,
  output logic [N_REQ-1:0]      GNT,
  output logic [N_REQ-1:0]      DONE,
  output logic [31:0]           RDATA,
  output logic                  NACK,
  output logic                  TMO,
  output logic                  BUSY,
  i2c_request_arbiter_if.master bus
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned PW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   id_q, id_d;
  logic [7:0]      addr_q, addr_d;
  logic [2:0]      len_q, len_d;
  logic [3:0][7:0] wdata_q, wdata_d;
  logic [3:0][7:0] rdata_q, rdata_d;
  logic [2:0]      idx_q, idx_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic            nack_q, nack_d;
  logic            tmo_q, tmo_d;

  logic [N_REQ-1:0] gnt_c, done_c;
  logic             wr_c, rd_c;
  logic [3:0]       add_c;
  logic [7:0]       wdat_c;

  logic [IW-1:0] win_id;
  logic          win_vld;

  logic [7:0]  req_addr_a  [N_REQ];
  logic [2:0]  req_len_a   [N_REQ];
  logic [31:0] req_wdata_a [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_addr_a[i]  = REQ_ADDR[8*i +: 8];
      req_len_a[i]   = REQ_LEN[3*i +: 3];
      req_wdata_a[i] = REQ_WDATA[32*i +: 32];
    end
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .BUS_CLK  (BUS_CLK),
    .RST      (RST),
    .req      (REQ),
    .grant_en ((state_q == IDLE) && win_vld),
    .win_id   (win_id),
    .win_vld  (win_vld)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    poll_d  = poll_q;
    nack_d  = nack_q;
    tmo_d   = tmo_q;
    gnt_c   = '0;
    done_c  = '0;
    wr_c    = 1'b0;
    rd_c    = 1'b0;
    add_c   = '0;
    wdat_c  = '0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          state_d = GRANT;
        end
      end

      GRANT: begin
        gnt_c[id_q] = 1'b1;
        addr_d  = req_addr_a[id_q];
        len_d   = req_len_a[id_q];
        wdata_d = req_wdata_a[id_q];
        rdata_d = '0;
        idx_d   = '0;
        tmo_d   = 1'b0;
        if (req_len_a[id_q] != 3'd0 && req_len_a[id_q] <= 3'(MAX_LEN)) begin
          nack_d  = 1'b0;
          state_d = W_ADDR;
        end else begin
          // Illegal length is rejected without touching the core.
          nack_d  = 1'b1;
          state_d = RESP;
        end
      end

      W_ADDR: begin
        wr_c    = 1'b1;
        add_c   = REG_ADDR;
        wdat_c  = addr_q;
        state_d = W_SIZEL;
      end

      W_SIZEL: begin
        wr_c    = 1'b1;
        add_c   = REG_SIZE_L;
        wdat_c  = {5'b0, len_q};
        state_d = W_SIZEH;
      end

      W_SIZEH: begin
        wr_c    = 1'b1;
        add_c   = REG_SIZE_H;
        state_d = addr_q[0] ? W_START : W_MEM;
      end

      W_MEM: begin
        wr_c   = 1'b1;
        add_c  = mem_addr(idx_q[1:0]);
        wdat_c = wdata_q[idx_q[1:0]];
        if (idx_q + 3'd1 == len_q) begin
          idx_d   = '0;
          state_d = W_START;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      W_START: begin
        wr_c    = 1'b1;
        add_c   = REG_START;
        poll_d  = '0;
        state_d = POLL_RD;
      end

      POLL_RD: begin
        rd_c    = 1'b1;
        add_c   = REG_START;
        state_d = POLL_CHK;
      end

      POLL_CHK: begin
        if (bus.CORE_RDATA[ST_DONE]) begin
          nack_d = bus.CORE_RDATA[ST_NACK];
          if (addr_q[0] && !bus.CORE_RDATA[ST_NACK]) begin
            idx_d   = '0;
            state_d = M_RD;
          end else begin
            state_d = RESP;
          end
        end else if (poll_q + PW'(1) == PW'(TIMEOUT)) begin
          state_d = ABORT;
        end else begin
          poll_d  = poll_q + PW'(1);
          state_d = POLL_RD;
        end
      end

      M_RD: begin
        rd_c    = 1'b1;
        add_c   = mem_addr(idx_q[1:0]);
        state_d = M_CAP;
      end

      M_CAP: begin
        rdata_d[idx_q[1:0]] = bus.CORE_RDATA;
        if (idx_q + 3'd1 == len_q) begin
          state_d = RESP;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = M_RD;
        end
      end

      ABORT: begin
        wr_c    = 1'b1;
        add_c   = REG_RST;
        tmo_d   = 1'b1;
        nack_d  = 1'b0;
        state_d = RESP;
      end

      RESP: begin
        done_c[id_q] = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      poll_q  <= '0;
      nack_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      poll_q  <= poll_d;
      nack_q  <= nack_d;
      tmo_q   <= tmo_d;
    end
  end

  // State-decoded outputs are masked by RST so strobes drop in the reset cycle.
  assign GNT            = RST ? '0 : gnt_c;
  assign DONE           = RST ? '0 : done_c;
  assign BUSY           = !RST && (state_q != IDLE);
  assign RDATA          = rdata_q;
  assign NACK           = nack_q;
  assign TMO            = tmo_q;
  assign bus.CORE_WR    = wr_c && !RST;
  assign bus.CORE_RD    = rd_c && !RST;
  assign bus.CORE_ADD   = RST ? '0 : ABUSWIDTH'(add_c);
  assign bus.CORE_WDATA = RST ? '0 : wdat_c;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter with a behavioural i2c_core model.
module tb_i2c_request_arbiter;
  import i2c_arb_pkg::*;

  localparam int unsigned N_REQ     = 2;
  localparam int unsigned ABUSWIDTH = 16;
  localparam int unsigned TIMEOUT   = 20;

  logic                BUS_CLK = 1'b0;
  logic                RST     = 1'b1;
  logic [N_REQ-1:0]    REQ       = '0;
  logic [8*N_REQ-1:0]  REQ_ADDR  = '0;
  logic [3*N_REQ-1:0]  REQ_LEN   = '0;
  logic [32*N_REQ-1:0] REQ_WDATA = '0;
  logic [N_REQ-1:0]    GNT, DONE;
  logic [31:0]         RDATA;
  logic                NACK, TMO, BUSY;

  i2c_request_arbiter_if #(.ABUSWIDTH(ABUSWIDTH)) bus_if ();

  i2c_request_arbiter #(.N_REQ(N_REQ), .ABUSWIDTH(ABUSWIDTH), .TIMEOUT(TIMEOUT)) dut (
    .BUS_CLK   (BUS_CLK),
    .RST       (RST),
    .REQ       (REQ),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_LEN   (REQ_LEN),
    .REQ_WDATA (REQ_WDATA),
    .GNT       (GNT),
    .DONE      (DONE),
    .RDATA     (RDATA),
    .NACK      (NACK),
    .TMO       (TMO),
    .BUSY      (BUSY),
    .bus       (bus_if)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge BUS_CLK) cyc <= cyc + 1;

  // core model controls, written only by the stimulus process
  int         done_at = 1;      // status done on this poll number (0 = never)
  logic [7:0] st_val  = 8'h01;
  logic [7:0] rom [16];

  // logs written only by the monitor process
  int         polls = 0;
  int         viol  = 0;
  int         wr_a[$], wr_d[$], rd_a[$], rd_c[$];
  int         gn_id[$], gn_cyc[$], dn_id[$], dn_cyc[$], dn_nt[$];
  logic [31:0] dn_rdata[$];

  function automatic int oh2id(input logic [N_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < int'(N_REQ); i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [63:0] pack8(input int q[$], input int base);
    logic [63:0] r = '0;
    for (int i = 0; i < 8 && base + i < q.size(); i++) r[8*i +: 8] = 8'(q[base+i]);
    return r;
  endfunction

  // i2c_core model and event monitor
  always @(negedge BUS_CLK) begin
    if (bus_if.CORE_WR && bus_if.CORE_RD) viol++;
    if ((bus_if.CORE_WR || bus_if.CORE_RD) && bus_if.CORE_ADD > 12) viol++;
    if (!bus_if.CORE_WR && bus_if.CORE_WDATA != 8'h00) viol++;
    if (bus_if.CORE_WR) begin
      wr_a.push_back(int'(bus_if.CORE_ADD));
      wr_d.push_back(int'(bus_if.CORE_WDATA));
      if (bus_if.CORE_ADD == 16'd1) polls = 0;
    end
    if (bus_if.CORE_RD) begin
      rd_a.push_back(int'(bus_if.CORE_ADD));
      rd_c.push_back(cyc);
      if (bus_if.CORE_ADD == 16'd1) begin
        polls++;
        bus_if.CORE_RDATA <= (done_at != 0 && polls >= done_at) ? st_val : 8'h00;
      end else begin
        bus_if.CORE_RDATA <= rom[bus_if.CORE_ADD[3:0]];
      end
    end
    if (GNT != '0) begin
      gn_id.push_back(oh2id(GNT));
      gn_cyc.push_back(cyc);
    end
    if (DONE != '0) begin
      dn_id.push_back(oh2id(DONE));
      dn_cyc.push_back(cyc);
      dn_rdata.push_back(RDATA);
      dn_nt.push_back(int'({NACK, TMO}));
    end
  end

  task automatic run_one(input int id, input logic [7:0] a, input logic [2:0] l,
                         input logic [31:0] wd, output int ok);
    @(negedge BUS_CLK);
    REQ_ADDR[8*id +: 8]   = a;
    REQ_LEN[3*id +: 3]    = l;
    REQ_WDATA[32*id +: 32] = wd;
    REQ[id]               = 1'b1;
    ok = 0;
    for (int k = 0; k < 200 && ok == 0; k++) begin
      @(negedge BUS_CLK);
      if (DONE[id]) ok = 1;
    end
    REQ[id] = 1'b0;
    check_eq($sformatf("done_seen_req%0d", id), 64'(ok), 64'd1);
    @(negedge BUS_CLK);
  endtask

  function automatic int last(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  initial begin
    int wi, ri, gi, di, ok, ndone, bad;
    int hold[2];

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[8] = 8'h11; rom[9] = 8'h22; rom[10] = 8'h33; rom[11] = 8'h44;

    // reset
    repeat (3) @(negedge BUS_CLK);
    check_eq("rst_outs_in_reset", {GNT, DONE, BUSY, NACK, TMO, bus_if.CORE_WR, bus_if.CORE_RD,
                                   bus_if.CORE_WDATA, bus_if.CORE_ADD}, 64'd0);
    RST = 1'b0;
    @(negedge BUS_CLK);
    check_eq("rst_outs_after", {RDATA, GNT, DONE, BUSY, NACK, TMO, bus_if.CORE_WR,
                                bus_if.CORE_RD, bus_if.CORE_WDATA}, 64'd0);

    // write: req0, 0xA0, 2 bytes
    wi = wr_a.size(); ri = rd_a.size();
    done_at = 1; st_val = 8'h01;
    run_one(0, 8'hA0, 3'd2, 32'h1234BEEF, ok);
    check_eq("wr_count",  wr_a.size() - wi, 6);
    check_eq("wr_addrs",  pack8(wr_a, wi), 64'h0000_0109_0804_0302);
    check_eq("wr_datas",  pack8(wr_d, wi), 64'h0000_00BE_EF00_02A0);
    check_eq("wr_reads",  pack8(rd_a, ri), 64'h01);
    check_eq("wr_done_id", last(dn_id), 0);
    check_eq("wr_nack_tmo", last(dn_nt), 0);
    check_eq("wr_gnt_to_poll", (ri < rd_c.size()) ? rd_c[ri] - last(gn_cyc) : -1, 7);
    check_eq("wr_gnt_to_done", last(dn_cyc) - last(gn_cyc), 9);

    // read: req1, 0xA1, 3 bytes
    wi = wr_a.size(); ri = rd_a.size();
    run_one(1, 8'hA1, 3'd3, 32'hFFFFFFFF, ok);
    check_eq("rd_wr_count", wr_a.size() - wi, 4);
    check_eq("rd_wr_addrs", pack8(wr_a, wi), 64'h0104_0302);
    check_eq("rd_wr_datas", pack8(wr_d, wi), 64'h0000_03A1);
    check_eq("rd_rd_count", rd_a.size() - ri, 4);
    check_eq("rd_rd_addrs", pack8(rd_a, ri), 64'h0A09_0801);
    check_eq("rd_done_id",  last(dn_id), 1);
    check_eq("rd_rdata",    (dn_rdata.size() > 0) ? dn_rdata[dn_rdata.size()-1] : 32'hDEAD, 32'h0033_2211);
    check_eq("rd_nack_tmo", last(dn_nt), 0);
    check_eq("rd_gnt_to_poll", (ri < rd_c.size()) ? rd_c[ri] - last(gn_cyc) : -1, 5);
    check_eq("rd_gnt_to_done", last(dn_cyc) - last(gn_cyc), 13);
    repeat (3) @(negedge BUS_CLK);
    check_eq("rd_rdata_held", RDATA, 32'h0033_2211);

    // NACK on third poll, read request
    wi = wr_a.size(); ri = rd_a.size();
    done_at = 3; st_val = 8'h03;
    run_one(0, 8'hA3, 3'd2, 32'h0, ok);
    check_eq("nk_wr_count", wr_a.size() - wi, 4);
    check_eq("nk_rd_addrs", pack8(rd_a, ri), 64'h01_0101);
    check_eq("nk_rd_count", rd_a.size() - ri, 3);
    check_eq("nk_done_id",  last(dn_id), 0);
    check_eq("nk_nack_tmo", last(dn_nt), 2);
    check_eq("nk_gnt_to_done", last(dn_cyc) - last(gn_cyc), 11);

    // timeout: status never done
    wi = wr_a.size(); ri = rd_a.size();
    done_at = 0; st_val = 8'h00;
    run_one(1, 8'hA4, 3'd1, 32'h0000005A, ok);
    check_eq("to_wr_count", wr_a.size() - wi, 6);
    check_eq("to_wr_addrs", pack8(wr_a, wi), 64'h0000_0001_0804_0302);
    check_eq("to_wr_datas", pack8(wr_d, wi), 64'h0000_0000_5A00_01A4);
    check_eq("to_polls", rd_a.size() - ri, 20);
    bad = 0;
    for (int i = ri; i < rd_a.size(); i++) if (rd_a[i] != 1) bad++;
    check_eq("to_poll_addr", bad, 0);
    check_eq("to_nack_tmo", last(dn_nt), 1);
    check_eq("to_gnt_to_done", last(dn_cyc) - last(gn_cyc), 47);

    // arbitration: both requesting continuously
    done_at = 1; st_val = 8'h01;
    gi = gn_id.size(); di = dn_id.size();
    @(negedge BUS_CLK);
    REQ_ADDR = {8'hA0, 8'hA0}; REQ_LEN = {3'd1, 3'd1}; REQ_WDATA = {32'h77, 32'h77};
    REQ = 2'b11; hold[0] = 0; hold[1] = 0; ndone = 0;
    for (int k = 0; k < 300 && ndone < 3; k++) begin
      @(negedge BUS_CLK);
      for (int r = 0; r < 2; r++) begin
        if (DONE[r]) begin
          REQ[r] = 1'b0; hold[r] = 2; ndone++;
        end else if (hold[r] > 0) begin
          hold[r]--;
          if (hold[r] == 0) REQ[r] = 1'b1;
        end
      end
    end
    REQ = 2'b00;
    check_eq("arb_done_count", ndone, 3);
    repeat (3) @(negedge BUS_CLK);
    check_eq("arb_gnt_count", gn_id.size() - gi, 3);
    check_eq("arb_gnt_order", pack8(gn_id, gi), 64'h00_0100);
    check_eq("arb_done_order", pack8(dn_id, di), 64'h00_0100);

    // illegal lengths: no core access, NACK
    for (int t = 0; t < 2; t++) begin
      wi = wr_a.size(); ri = rd_a.size();
      run_one(0, 8'hA0, (t == 0) ? 3'd0 : 3'd5, 32'h0, ok);
      check_eq($sformatf("len%0d_strobes", t * 5), (wr_a.size() - wi) + (rd_a.size() - ri), 0);
      check_eq($sformatf("len%0d_nack_tmo", t * 5), last(dn_nt), 2);
      check_eq($sformatf("len%0d_gnt_to_done", t * 5), last(dn_cyc) - last(gn_cyc), 1);
    end

    // reset during W_MEM
    @(negedge BUS_CLK);
    REQ_ADDR[15:8] = 8'hA6; REQ_LEN[5:3] = 3'd4; REQ_WDATA[63:32] = 32'h44332211;
    REQ[1] = 1'b1;
    ok = 0;
    for (int k = 0; k < 50 && ok == 0; k++) begin
      @(negedge BUS_CLK);
      if (GNT[1]) ok = 1;
    end
    check_eq("rstm_gnt_seen", ok, 1);
    repeat (5) @(negedge BUS_CLK);
    check_eq("rstm_in_wmem", {bus_if.CORE_WR, bus_if.CORE_WDATA, bus_if.CORE_ADD}, {1'b1, 8'h22, 16'd9});
    di = dn_id.size();
    RST = 1'b1; REQ = '0;
    @(negedge BUS_CLK);
    check_eq("rstm_outs", {GNT, DONE, BUSY, NACK, TMO, bus_if.CORE_WR, bus_if.CORE_RD,
                           bus_if.CORE_WDATA, bus_if.CORE_ADD}, 64'd0);
    check_eq("rstm_rdata", RDATA, 32'd0);
    @(negedge BUS_CLK);
    RST = 1'b0;
    repeat (2) @(negedge BUS_CLK);
    check_eq("rstm_no_done", dn_id.size() - di, 0);
    wi = wr_a.size();
    run_one(0, 8'hB0, 3'd1, 32'h99, ok);
    check_eq("rstm_after_wr", pack8(wr_d, wi), 64'h0000_0000_9900_01B0);
    check_eq("rstm_after_id", last(dn_id), 0);
    check_eq("rstm_after_nt", last(dn_nt), 0);

    check_eq("bus_rules", viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
